// File: rtl/imem_pkg.sv
// Shared opcode, instruction-type, fault and NOP definitions for the fetch/decode front end.
package imem_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IT_R       = 3'd0,
        IT_I       = 3'd1,
        IT_S       = 3'd2,
        IT_B       = 3'd3,
        IT_U       = 3'd4,
        IT_J       = 3'd5,
        IT_ILLEGAL = 3'd6
    } instr_type_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Instruction format from the major opcode.
    function automatic instr_type_e decode_type(input logic [6:0] opcode);
        instr_type_e t;
        case (opcode)
            OP_OP:                                t = IT_R;
            OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM: t = IT_I;
            OP_STORE:                             t = IT_S;
            OP_BRANCH:                            t = IT_B;
            OP_LUI, OP_AUIPC:                     t = IT_U;
            OP_JAL:                               t = IT_J;
            default:                              t = IT_ILLEGAL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imem_fetch_decode_imm_gen.sv
// Sign-extended immediate from a raw RV32I instruction and its decoded format.
module imm_gen
    import imem_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [2:0]  itype_i,
    output logic [31:0] imm_o
);

    // The opcode bits carry no immediate payload.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm_o = '0;
        case (instr_type_e'(itype_i))
            IT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IT_B: imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IT_U: imm_o = {instr_i[31:12], 12'b0};
            IT_J: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imem_fetch_decode.sv
// Instruction memory with program-load port, one-cycle registered fetch and
// integrated decode, returning results through a held valid/ready output register.
module imem_fetch_decode
    import imem_pkg::*;
#(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned DEPTH             = 256,
    parameter bit          RESET_PC_FAULT_EN = 1'b1,
    localparam int unsigned ADDR_W           = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iwr_en,
    input  logic [ADDR_W-1:0] iwr_addr,
    input  logic [XLEN-1:0]   data_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   pci,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   instr_o,
    output logic [6:0]        iop_c,
    output logic [4:0]        iwr_r,
    output logic [4:0]        ird_r1,
    output logic [4:0]        ird_r2,
    output logic [2:0]        ifun3,
    output logic [6:0]        ifun7,
    output logic [2:0]        itype,
    output logic [XLEN-1:0]   imm,
    output logic [1:0]        fault
);

    logic [XLEN-1:0] mem_q [DEPTH];

    logic            out_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] imm_q;
    instr_type_e     itype_q;
    logic [1:0]      fault_q;

    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] imm_d;
    instr_type_e     itype_d;
    logic [1:0]      fault_d;

    logic [ADDR_W-1:0] word_idx;
    logic              out_of_range;
    logic              fire;

    assign req_ready    = !out_valid_q || out_ready;
    assign fire         = req_valid && req_ready;
    assign word_idx     = pci[ADDR_W+1:2];
    assign out_of_range = (pci >> (ADDR_W + 2)) != '0;

    // Fault classification and memory read of the requested word; faults substitute a NOP.
    always_comb begin
        fault_d = FAULT_NONE;
        if (pci[1:0] != 2'b00) begin
            fault_d = FAULT_MISALIGN;
        end else if (RESET_PC_FAULT_EN && out_of_range) begin
            fault_d = FAULT_RANGE;
        end
        instr_d = (fault_d == FAULT_NONE) ? mem_q[word_idx] : NOP_INSTR;
        itype_d = (fault_d == FAULT_NONE) ? decode_type(instr_d[6:0]) : IT_I;
    end

    imm_gen u_imm_gen (
        .instr_i (instr_d),
        .itype_i (itype_d),
        .imm_o   (imm_d)
    );

    // Program-load port; a same-cycle fetch sees the pre-write word.
    always_ff @(posedge clk) begin
        if (iwr_en) begin
            mem_q[iwr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            instr_q     <= NOP_INSTR;
            imm_q       <= '0;
            itype_q     <= IT_I;
            fault_q     <= FAULT_NONE;
        end else if (fire) begin
            out_valid_q <= !flush;
            pc_q        <= pci;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            itype_q     <= itype_d;
            fault_q     <= fault_d;
        end else if (flush || out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign pc_o      = pc_q;
    assign instr_o   = instr_q;
    assign iop_c     = instr_q[6:0];
    assign iwr_r     = instr_q[11:7];
    assign ird_r1    = instr_q[19:15];
    assign ird_r2    = instr_q[24:20];
    assign ifun3     = instr_q[14:12];
    assign ifun7     = instr_q[31:25];
    assign itype     = itype_q;
    assign imm       = imm_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch_decode.sv
// Self-checking bench for imem_fetch_decode: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of memory, handshake and decode.
module tb_imem_fetch_decode;

    logic        clk = 1'b0;
    logic        rst, iwr_en, req_valid, flush, out_ready;
    logic [7:0]  iwr_addr;
    logic [31:0] data_in, pci;
    logic        req_ready, out_valid;
    logic [31:0] pc_o, instr_o, imm;
    logic [6:0]  iop_c, ifun7;
    logic [4:0]  iwr_r, ird_r1, ird_r2;
    logic [2:0]  ifun3, itype;
    logic [1:0]  fault;

    always #5 clk = ~clk;

    imem_fetch_decode #(.XLEN(32), .DEPTH(256), .RESET_PC_FAULT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .iwr_en(iwr_en), .iwr_addr(iwr_addr), .data_in(data_in),
        .req_valid(req_valid), .req_ready(req_ready), .pci(pci), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o), .instr_o(instr_o),
        .iop_c(iop_c), .iwr_r(iwr_r), .ird_r1(ird_r1), .ird_r2(ird_r2), .ifun3(ifun3),
        .ifun7(ifun7), .itype(itype), .imm(imm), .fault(fault)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [31:0] mem_m [256];
    logic        m_valid = 1'b0;
    logic        m_reset = 1'b0;
    logic [31:0] m_pc, m_instr;
    logic [1:0]  m_fault;

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'd1 << (n - 1);
        return (v ^ m) - m;
    endfunction

    function automatic logic [2:0] exp_type(input logic [31:0] w);
        case (w[6:0])
            7'h33:                      return 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
            7'h23:                      return 3'd2;
            7'h63:                      return 3'd3;
            7'h37, 7'h17:               return 3'd4;
            7'h6F:                      return 3'd5;
            default:                    return 3'd6;
        endcase
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] w);
        case (exp_type(w))
            3'd1: return sext(32'(w[31:20]), 12);
            3'd2: return sext(32'({w[31:25], w[11:7]}), 12);
            3'd3: return sext(32'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
            3'd4: return w & 32'hFFFF_F000;
            3'd5: return sext(32'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid || m_reset) begin
            chk("pc_o", pc_o, m_pc);
            chk("instr_o", instr_o, m_instr);
            chk("iop_c", 32'(iop_c), 32'(m_instr[6:0]));
            chk("rd", 32'(iwr_r), 32'(m_instr[11:7]));
            chk("rs1", 32'(ird_r1), 32'(m_instr[19:15]));
            chk("rs2", 32'(ird_r2), 32'(m_instr[24:20]));
            chk("funct3", 32'(ifun3), 32'(m_instr[14:12]));
            chk("funct7", 32'(ifun7), 32'(m_instr[31:25]));
            chk("itype", 32'(itype), 32'(exp_type(m_instr)));
            chk("imm", imm, exp_imm(m_instr));
            chk("fault", 32'(fault), 32'(m_fault));
        end
    endtask

    // One clock: drive inputs, check ready, advance the model at the edge, check outputs.
    task automatic step(input logic r, input logic we, input logic [7:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [31:0] pc, input logic fl, input logic ordy);
        logic exp_ready, fire;
        rst = r; iwr_en = we; iwr_addr = wa; data_in = wd;
        req_valid = rv; pci = pc; flush = fl; out_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        fire = rv && exp_ready;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_reset = 1'b1; m_pc = 32'd0; m_instr = 32'h13; m_fault = 2'd0;
        end else if (fire) begin
            m_fault = (pc[1:0] != 2'd0) ? 2'd1 : ((pc >= 32'd1024) ? 2'd2 : 2'd0);
            m_pc    = pc;
            m_instr = (m_fault != 2'd0) ? 32'h13 : mem_m[pc[9:2]];
            m_valid = !fl;
            m_reset = 1'b0;
        end else if (fl || ordy) begin
            m_valid = 1'b0;
        end
        if (we) mem_m[wa] = wd;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic ordy);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, pc, 1'b0, ordy);
    endtask

    initial begin
        logic [31:0] w, pc;
        int k;
        rst = 1'b1; iwr_en = 1'b0; iwr_addr = '0; data_in = '0;
        req_valid = 1'b0; pci = '0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("lit_rst_valid", 32'(out_valid), 32'd0);
        chk("lit_rst_instr", instr_o, 32'h0000_0013);
        chk("lit_rst_op", 32'(iop_c), 32'h13);
        chk("lit_rst_type", 32'(itype), 32'd1);
        chk("lit_rst_pc", pc_o, 32'd0);

        // Program load
        for (int i = 0; i < 256; i++) begin
            w = (i == 0) ? 32'h0050_0093 : (i == 2) ? 32'hFE00_0EE3 :
                (i == 3) ? 32'h0020_81B3 : rand_instr();
            step(1'b0, 1'b1, 8'(i), w, 1'b0, 32'd0, 1'b0, 1'b1);
        end

        fetch(32'd0, 1'b1);
        chk("lit_addi_valid", 32'(out_valid), 32'd1);
        chk("lit_addi_type", 32'(itype), 32'd1);
        chk("lit_addi_rd", 32'(iwr_r), 32'd1);
        chk("lit_addi_rs1", 32'(ird_r1), 32'd0);
        chk("lit_addi_imm", imm, 32'd5);
        chk("lit_addi_fault", 32'(fault), 32'd0);
        idle();

        fetch(32'd0, 1'b1);
        chk("lit_b2b0_pc", pc_o, 32'd0);
        fetch(32'd4, 1'b1);
        chk("lit_b2b1_valid", 32'(out_valid), 32'd1);
        chk("lit_b2b1_pc", pc_o, 32'd4);
        fetch(32'd8, 1'b1);
        chk("lit_beq_valid", 32'(out_valid), 32'd1);
        chk("lit_beq_type", 32'(itype), 32'd3);
        chk("lit_beq_imm", imm, 32'hFFFF_FFFC);
        idle();
        chk("lit_consumed", 32'(out_valid), 32'd0);

        // Hold with out_ready low
        fetch(32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            fetch(32'd4, 1'b0);
            chk("lit_hold_pc", pc_o, 32'd0);
            chk("lit_hold_valid", 32'(out_valid), 32'd1);
        end
        fetch(32'd4, 1'b1);
        chk("lit_release_pc", pc_o, 32'd4);
        idle();

        fetch(32'd2, 1'b1);
        chk("lit_mis_fault", 32'(fault), 32'd1);
        chk("lit_mis_instr", instr_o, 32'h0000_0013);
        chk("lit_mis_valid", 32'(out_valid), 32'd1);
        fetch(32'h400, 1'b1);
        chk("lit_oor_fault", 32'(fault), 32'd2);
        idle();

        // Same-cycle write and fetch of word 3
        step(1'b0, 1'b1, 8'd3, 32'h0000_006F, 1'b1, 32'hC, 1'b0, 1'b1);
        chk("lit_rfirst_instr", instr_o, 32'h0020_81B3);
        chk("lit_rfirst_type", 32'(itype), 32'd0);
        fetch(32'hC, 1'b1);
        chk("lit_jal_type", 32'(itype), 32'd5);
        chk("lit_jal_imm", imm, 32'd0);
        idle();

        fetch(32'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("lit_flush_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 32'd4, 1'b1, 1'b1);
        chk("lit_flush_fire_valid", 32'(out_valid), 32'd0);

        fetch(32'd8, 1'b1);
        step(1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 32'd4, 1'b0, 1'b1);
        chk("lit_rst2_valid", 32'(out_valid), 32'd0);
        chk("lit_rst2_instr", instr_o, 32'h0000_0013);
        chk("lit_rst2_pc", pc_o, 32'd0);
        idle();
        chk("lit_rst2_next_valid", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 9);
            pc = {22'd0, 8'($urandom), 2'b00};
            if (k == 0) pc = pc | 32'($urandom_range(1, 3));
            else if (k == 1) pc = pc | (32'd1 << $urandom_range(10, 31));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, 8'($urandom), rand_instr(),
                 $urandom_range(0, 3) != 0, pc, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
